time_of_day_counter: RTL and testbench

Binary time-of-day counter (hours/minutes/seconds) with built-in 1 Hz prescaler and a RUN/SET mode machine for setting the time from pushbuttons. It sits directly upstream of the 24-hour seven-segment decoder (sevdectwentyfhr). Its 8-bit hours output drives that decoder's a_in, and the minutes/seconds outputs feed the matching minute/second decoders. Hours output is guaranteed to stay in 0..23, so the decoder never receives an out-of-range code.

---
 rtl/time_of_day_counter.sv | 119 +++++++++++
 tb/tb_time_of_day_counter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/time_of_day_counter.sv
// Binary hours/minutes/seconds counter with a built-in 1 Hz prescaler.
// A RUN/SET mode machine lets pushbuttons set the time.
module time_of_day_counter #(
    parameter int CLK_DIV   = 100000000,
    parameter int HOURS_MAX = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       hr_btn,
    input  logic       min_btn,
    output logic [7:0] hours,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic       set_mode,
    output logic       sec_tick,
    output logic       day_wrap
);
    localparam int              PW       = $clog2(CLK_DIV);
    localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [7:0]      H_MAX    = 8'(HOURS_MAX);

    typedef enum logic {RUN, SET} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    hours_q, hours_d;
    logic [7:0]    minutes_q, minutes_d;
    logic [7:0]    seconds_q, seconds_d;
    logic          sec_tick_q, sec_tick_d;
    logic          day_wrap_q, day_wrap_d;
    logic          mode_h_q, hr_h_q, min_h_q;
    logic          mode_ev, hr_ev, min_ev;

    assign mode_ev = mode_btn & ~mode_h_q;
    assign hr_ev   = hr_btn & ~hr_h_q;
    assign min_ev  = min_btn & ~min_h_q;

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        hours_d    = hours_q;
        minutes_d  = minutes_q;
        seconds_d  = seconds_q;
        sec_tick_d = 1'b0;
        day_wrap_d = 1'b0;
        if (state_q == RUN) begin
            // A mode press wins over a coincident terminal count; that second is dropped.
            if (mode_ev) begin
                state_d   = SET;
                pre_d     = '0;
                seconds_d = '0;
            end else if (pre_q == PRE_LAST) begin
                pre_d      = '0;
                sec_tick_d = 1'b1;
                if (seconds_q == 8'd59) begin
                    seconds_d = '0;
                    if (minutes_q == 8'd59) begin
                        minutes_d = '0;
                        if (hours_q == H_MAX) begin
                            hours_d    = '0;
                            day_wrap_d = 1'b1;
                        end else begin
                            hours_d = hours_q + 8'd1;
                        end
                    end else begin
                        minutes_d = minutes_q + 8'd1;
                    end
                end else begin
                    seconds_d = seconds_q + 8'd1;
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end else begin
            pre_d     = '0;
            seconds_d = '0;
            if (hr_ev)
                hours_d = (hours_q == H_MAX) ? 8'd0 : hours_q + 8'd1;
            if (min_ev)
                minutes_d = (minutes_q == 8'd59) ? 8'd0 : minutes_q + 8'd1;
            if (mode_ev)
                state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pre_q      <= '0;
            hours_q    <= '0;
            minutes_q  <= '0;
            seconds_q  <= '0;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
            mode_h_q   <= 1'b0;
            hr_h_q     <= 1'b0;
            min_h_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            seconds_q  <= seconds_d;
            sec_tick_q <= sec_tick_d;
            day_wrap_q <= day_wrap_d;
            mode_h_q   <= mode_btn;
            hr_h_q     <= hr_btn;
            min_h_q    <= min_btn;
        end
    end

    assign hours    = hours_q;
    assign minutes  = minutes_q;
    assign seconds  = seconds_q;
    assign set_mode = (state_q == SET);
    assign sec_tick = sec_tick_q;
    assign day_wrap = day_wrap_q;
endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench for time_of_day_counter: each step queues its stimulus with the
// expected {hours, minutes, seconds, set_mode, sec_tick, day_wrap} one edge later.
module tb_time_of_day_counter;
    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_btn = 1'b0, hr_btn = 1'b0, min_btn = 1'b0;
    logic [7:0] hours, minutes, seconds;
    logic       set_mode, sec_tick, day_wrap;

    time_of_day_counter #(.CLK_DIV(CLK_DIV), .HOURS_MAX(23)) dut (
        .clk(clk), .rst(rst), .mode_btn(mode_btn), .hr_btn(hr_btn), .min_btn(min_btn),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .set_mode(set_mode), .sec_tick(sec_tick), .day_wrap(day_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        r, mb, hb, nb;
        logic [26:0] v;
    } step_t;

    step_t sq[$];
    int    passed = 0, total = 0;
    int    eh = 0, em = 0, es = 0;
    logic  esm = 1'b0;

    function automatic logic [26:0] obs();
        return {hours, minutes, seconds, set_mode, sec_tick, day_wrap};
    endfunction

    function automatic void push(string name, logic r, logic mb, logic hb, logic nb,
                                 logic tk, logic dw);
        step_t s;
        s.name = name; s.r = r; s.mb = mb; s.hb = hb; s.nb = nb;
        s.v = {eh[7:0], em[7:0], es[7:0], esm, tk, dw};
        sq.push_back(s);
    endfunction

    // One RUN second starting from a zero prescaler: CLK_DIV-1 quiet cycles, then the tick.
    function automatic void run_sec(string name);
        logic w;
        for (int i = 0; i < CLK_DIV - 1; i++) push(name, 0, 0, 0, 0, 0, 0);
        w = (eh == 23 && em == 59 && es == 59);
        es++;
        if (es == 60) begin
            es = 0; em++;
            if (em == 60) begin
                em = 0; eh++;
                if (eh == 24) eh = 0;
            end
        end
        push(name, 0, 0, 0, 0, 1, w);
    endfunction

    // Button press in SET followed by a release cycle.
    function automatic void press(string name, logic hb, logic nb);
        if (hb) eh = (eh == 23) ? 0 : eh + 1;
        if (nb) em = (em == 59) ? 0 : em + 1;
        push(name, 0, 0, hb, nb, 0, 0);
        push(name, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void toggle(string name);
        if (!esm) es = 0;
        esm = ~esm;
        push(name, 0, 1, 0, 0, 0, 0);
        push(name, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic test_reset();
        step_t s;
        push("reset", 1, 0, 0, 0, 0, 0);
        push("reset", 1, 0, 0, 0, 0, 0);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            rst = s.r; mode_btn = s.mb; hr_btn = s.hb; min_btn = s.nb;
            @(posedge clk); #1;
            total++;
            if (obs() !== s.v) $display("FAIL %s: got %h want %h", s.name, obs(), s.v);
            else passed++;
        end
    endtask

    task automatic test_run();
        step_t s;
        for (int k = 0; k < 5; k++) run_sec("run");
        while (sq.size() > 0) begin
            s = sq.pop_front();
            rst = s.r; mode_btn = s.mb; hr_btn = s.hb; min_btn = s.nb;
            @(posedge clk); #1;
            total++;
            if (obs() !== s.v) $display("FAIL %s: got %h want %h", s.name, obs(), s.v);
            else passed++;
        end
    endtask

    task automatic test_simultaneous();
        step_t s;
        for (int i = 0; i < CLK_DIV - 1; i++) push("simul_pre", 0, 0, 0, 0, 0, 0);
        esm = 1'b1; es = 0;
        push("simul_mode_tc", 0, 1, 0, 0, 0, 0);
        push("simul_after", 0, 0, 0, 0, 0, 0);
        push("simul_after", 0, 0, 0, 0, 0, 0);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            rst = s.r; mode_btn = s.mb; hr_btn = s.hb; min_btn = s.nb;
            @(posedge clk); #1;
            total++;
            if (obs() !== s.v) $display("FAIL %s: got %h want %h", s.name, obs(), s.v);
            else passed++;
        end
    endtask

    task automatic test_set_incr();
        step_t s;
        eh = 1;
        for (int i = 0; i < 10; i++) push("hold_hr", 0, 0, 1, 0, 0, 0);
        push("hold_hr_rel", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 23; i++) press("hr_24", 1, 0);
        for (int i = 0; i < 60; i++) press("min_60", 0, 1);
        press("hr_min_both", 1, 1);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            rst = s.r; mode_btn = s.mb; hr_btn = s.hb; min_btn = s.nb;
            @(posedge clk); #1;
            total++;
            if (obs() !== s.v) $display("FAIL %s: got %h want %h", s.name, obs(), s.v);
            else passed++;
        end
    endtask

    task automatic test_day_wrap();
        step_t s;
        for (int i = 0; i < 21; i++) press("set_hr", 1, 0);
        for (int i = 0; i < 57; i++) press("set_min", 0, 1);
        eh = 23; em = 59; esm = 1'b0;
        push("exit_with_incr", 0, 1, 1, 1, 0, 0);
        for (int k = 0; k < 60; k++) run_sec("day_wrap");
        while (sq.size() > 0) begin
            s = sq.pop_front();
            rst = s.r; mode_btn = s.mb; hr_btn = s.hb; min_btn = s.nb;
            @(posedge clk); #1;
            total++;
            if (obs() !== s.v) $display("FAIL %s: got %h want %h", s.name, obs(), s.v);
            else passed++;
        end
    endtask

    task automatic test_set_freeze();
        step_t s;
        for (int k = 0; k < 37; k++) run_sec("to_37");
        toggle("enter_set");
        for (int i = 0; i < 38; i++) push("set_frozen", 0, 0, 0, 0, 0, 0);
        esm = 1'b0;
        push("exit_set", 0, 1, 0, 0, 0, 0);
        run_sec("first_after_exit");
        while (sq.size() > 0) begin
            s = sq.pop_front();
            rst = s.r; mode_btn = s.mb; hr_btn = s.hb; min_btn = s.nb;
            @(posedge clk); #1;
            total++;
            if (obs() !== s.v) $display("FAIL %s: got %h want %h", s.name, obs(), s.v);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        step_t s;
        toggle("enter_set2");
        for (int i = 0; i < 12; i++) press("set_12", 1, 0);
        for (int i = 0; i < 34; i++) press("set_34", 0, 1);
        esm = 1'b0;
        push("exit_set2", 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 56; k++) run_sec("to_123456");
        push("pre_1", 0, 0, 0, 0, 0, 0);
        push("pre_2", 0, 0, 0, 0, 0, 0);
        eh = 0; em = 0; es = 0; esm = 1'b0;
        push("rst_mid", 1, 0, 0, 0, 0, 0);
        run_sec("after_rst");
        run_sec("after_rst");
        while (sq.size() > 0) begin
            s = sq.pop_front();
            rst = s.r; mode_btn = s.mb; hr_btn = s.hb; min_btn = s.nb;
            @(posedge clk); #1;
            total++;
            if (obs() !== s.v) $display("FAIL %s: got %h want %h", s.name, obs(), s.v);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_simultaneous();
        test_set_incr();
        test_day_wrap();
        test_set_freeze();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
